// File: rtl/mock_ram_hs_if.sv
// Request/response bundle for mock_ram_hs: valid/ready request channel,
// valid/ready read-response channel and the outstanding-read credit count.
interface mock_ram_hs_if #(
    parameter int W_DATA = 32,
    parameter int W_ADDR = 8,
    parameter int W_NP   = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [W_ADDR-1:0]     req_addr;
    logic [W_DATA-1:0]     req_wdata;
    logic [W_DATA/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [W_DATA-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic [W_NP-1:0]       n_pending;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, n_pending
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, n_pending
    );
endinterface

// File: rtl/mock_ram_hs.sv
// Handshaked SRAM model: byte-enabled writes, fixed-latency in-order reads through a
// credit-limited response FIFO. Define MOCK_RAM_STALL_EN for LFSR-driven request stalls.
module mock_ram_hs #(
    parameter int W_DATA    = 32,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    mock_ram_hs_if.slave  bus
);
    localparam int W_ADDR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int W_BE   = W_DATA / 8;
    localparam int W_NP   = $clog2(RSP_DEPTH + 1);
    localparam int W_PTR  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [W_ADDR:0]    DEPTH_L  = (W_ADDR + 1)'(DEPTH);
    localparam logic [W_PTR-1:0]   PTR_LAST = W_PTR'(RSP_DEPTH - 1);
    localparam logic [W_NP-1:0]    CREDITS  = W_NP'(RSP_DEPTH);

    logic [W_DATA-1:0] r_mem [DEPTH];

    logic              r_pipe_vld  [LATENCY];
    logic [W_DATA-1:0] r_pipe_data [LATENCY];
    logic              r_pipe_err  [LATENCY];

    logic [W_DATA-1:0] r_fifo_data [RSP_DEPTH];
    logic              r_fifo_err  [RSP_DEPTH];
    logic [W_PTR-1:0]  r_wr_ptr;
    logic [W_PTR-1:0]  r_rd_ptr;
    logic [W_NP-1:0]   r_count;
    logic [W_NP-1:0]   r_n_pending;

    logic              w_credit_ok;
    logic              w_accept;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_in_range;
    logic              w_push;
    logic              w_pop;
    logic              w_rsp_valid;
    logic [W_DATA-1:0] w_rd_word;

    assign w_credit_ok = (r_n_pending < CREDITS);

`ifdef MOCK_RAM_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci LFSR, taps 16,14,13,11 expressed as right-shift bit positions 0,2,3,5.
    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_lfsr <= 16'hACE1;
        else       r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end

    assign bus.req_ready = rstn && w_credit_ok && (r_lfsr[1:0] != 2'b00);
`else
    assign bus.req_ready = rstn && w_credit_ok;
`endif

    assign w_accept   = bus.req_valid && bus.req_ready;
    assign w_rd_acc   = w_accept && !bus.req_write;
    assign w_wr_acc   = w_accept && bus.req_write;
    assign w_in_range = ({1'b0, bus.req_addr} < DEPTH_L);
    assign w_rd_word  = w_in_range ? r_mem[bus.req_addr] : '0;

    // NOTE: the array has no reset on purpose; contents survive rstn, and a reset
    // branch here would turn the RAM into thousands of resettable flops.
    always_ff @(posedge clk) begin
        if (w_wr_acc && w_in_range) begin
            for (int b = 0; b < W_BE; b++) begin
                if (bus.req_be[b]) r_mem[bus.req_addr][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the pre-edge value of its neighbour, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_data[i] <= '0;
                r_pipe_err[i]  <= 1'b0;
            end
        end else begin
            r_pipe_vld[0]  <= w_rd_acc;
            r_pipe_data[0] <= w_rd_word;
            r_pipe_err[0]  <= !w_in_range;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
                r_pipe_err[i]  <= r_pipe_err[i-1];
            end
        end
    end

    assign w_push      = r_pipe_vld[LATENCY-1];
    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= r_pipe_data[LATENCY-1];
            r_fifo_err[r_wr_ptr]  <= r_pipe_err[LATENCY-1];
        end
    end

    // Credit limiting guarantees a push never meets a full FIFO without a pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_n_pending <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + W_NP'(w_push) - W_NP'(w_pop);
            case ({w_rd_acc, w_pop})
                2'b10:   r_n_pending <= r_n_pending + 1'b1;
                2'b01:   r_n_pending <= r_n_pending - 1'b1;
                default: r_n_pending <= r_n_pending;
            endcase
        end
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = w_rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.rsp_err   = w_rsp_valid ? r_fifo_err[r_rd_ptr] : 1'b0;
    assign bus.n_pending = r_n_pending;
endmodule

// File: tb/tb_mock_ram_hs.sv
// Directed bench for mock_ram_hs (DEPTH=200 so out-of-range addresses are reachable).
module tb_mock_ram_hs;
    localparam int W_DATA    = 32;
    localparam int DEPTH     = 200;
    localparam int LATENCY   = 2;
    localparam int RSP_DEPTH = 4;
    localparam int W_ADDR    = 8;
    localparam int W_NP      = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mock_ram_hs_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .W_NP(W_NP)) bus ();

    mock_ram_hs #(
        .W_DATA(W_DATA), .DEPTH(DEPTH), .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits (bounded) for req_ready, returns just after the accept edge.
    task automatic do_req(input logic wr, input logic [7:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
        int n;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_be    = be;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            step();
            n++;
        end
        check($sformatf("req_ready_a%0d", addr), {31'b0, bus.req_ready}, 32'd1);
        step();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
    endtask

    // Waits (bounded) for a response, checks it, then lets it pop (rsp_ready assumed 1).
    task automatic wait_rsp(input string tag, input logic [31:0] exp_data, input logic exp_err);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
        check({tag, "_rdata"}, bus.rsp_rdata, exp_data);
        check({tag, "_err"},   {31'b0, bus.rsp_err}, {31'b0, exp_err});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        #3;
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
        check("rst_n_pending", {29'b0, bus.n_pending}, 32'd0);
        #19 rstn = 1'b1;
        step();
`ifndef MOCK_RAM_STALL_EN
        check("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
`endif

        // 1: full write, read back with exact latency
        do_req(1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 8'd5, 32'h0, 4'h0);
        check("t1_pending", {29'b0, bus.n_pending}, 32'd1);
        check("t1_lat0", {31'b0, bus.rsp_valid}, 32'd0);
        step();
        check("t1_lat1", {31'b0, bus.rsp_valid}, 32'd0);
        step();
        check("t1_lat2", {31'b0, bus.rsp_valid}, 32'd1);
        check("t1_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        check("t1_err", {31'b0, bus.rsp_err}, 32'd0);
        step();
        check("t1_drained", {29'b0, bus.n_pending}, 32'd0);
        check("t1_empty", {31'b0, bus.rsp_valid}, 32'd0);

        // 2: partial byte-enable merge
        do_req(1'b1, 8'd5, 32'h11223344, 4'b0101);
        do_req(1'b0, 8'd5, 32'h0, 4'h0);
        wait_rsp("t2", 32'hDE22BE44, 1'b0);

        // 3: credit limit under backpressure, then ordered drain
        for (int i = 0; i < 6; i++) do_req(1'b1, 8'(10 + i), 32'hA0000000 + i, 4'hF);
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_req(1'b0, 8'(10 + i), 32'h0, 4'h0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'd14;
        step();
        step();
        check("t3_stalled_ready", {31'b0, bus.req_ready}, 32'd0);
        check("t3_full_pending", {29'b0, bus.n_pending}, 32'd4);
        check("t3_rsp_held", {31'b0, bus.rsp_valid}, 32'd1);
        check("t3_head_data", bus.rsp_rdata, 32'hA0000000);
        bus.rsp_ready = 1'b1;
        fork
            begin
                do_req(1'b0, 8'd14, 32'h0, 4'h0);
                do_req(1'b0, 8'd15, 32'h0, 4'h0);
            end
            begin
                for (int j = 0; j < 6; j++) wait_rsp($sformatf("t3_rsp%0d", j), 32'hA0000000 + j, 1'b0);
            end
        join
        check("t3_drained", {29'b0, bus.n_pending}, 32'd0);

        // 4: read followed by a write to the same word returns the old value
        do_req(1'b0, 8'd5, 32'h0, 4'h0);
        do_req(1'b1, 8'd5, 32'h0, 4'hF);
        wait_rsp("t4_old", 32'hDE22BE44, 1'b0);
        do_req(1'b0, 8'd5, 32'h0, 4'h0);
        wait_rsp("t4_new", 32'h0, 1'b0);

        // 5: out-of-range reads/writes and the last valid word
        do_req(1'b1, 8'd50, 32'h12345678, 4'hF);
        do_req(1'b1, 8'd199, 32'hCAFEF00D, 4'hF);
        do_req(1'b0, 8'd250, 32'h0, 4'h0);
        wait_rsp("t5_oor_rd", 32'h0, 1'b1);
        do_req(1'b1, 8'd250, 32'hFFFFFFFF, 4'hF);
        do_req(1'b0, 8'd250, 32'h0, 4'h0);
        wait_rsp("t5_oor_rd2", 32'h0, 1'b1);
        do_req(1'b0, 8'd50, 32'h0, 4'h0);
        wait_rsp("t5_a50", 32'h12345678, 1'b0);
        do_req(1'b0, 8'd199, 32'h0, 4'h0);
        wait_rsp("t5_a199", 32'hCAFEF00D, 1'b0);

        // 6: reset with reads in flight discards them, memory retained
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 8'd10, 32'h0, 4'h0);
        do_req(1'b0, 8'd11, 32'h0, 4'h0);
        do_req(1'b0, 8'd12, 32'h0, 4'h0);
        rstn = 1'b0;
        #1;
        check("t6_rst_ready", {31'b0, bus.req_ready}, 32'd0);
        check("t6_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("t6_rst_pending", {29'b0, bus.n_pending}, 32'd0);
        check("t6_rst_rdata", bus.rsp_rdata, 32'd0);
        step();
        #4 rstn = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | bus.rsp_valid;
        end
        check("t6_no_ghost_rsp", {31'b0, seen}, 32'd0);
        check("t6_pending_zero", {29'b0, bus.n_pending}, 32'd0);
        do_req(1'b0, 8'd10, 32'h0, 4'h0);
        wait_rsp("t6_retained", 32'hA0000000, 1'b0);

`ifdef MOCK_RAM_STALL_EN
        begin
            logic [31:0] pat_a;
            logic [31:0] pat_b;
            rstn = 1'b0;
            step();
            #4 rstn = 1'b1;
            for (int i = 0; i < 32; i++) begin
                step();
                pat_a[i] = bus.req_ready;
            end
            rstn = 1'b0;
            step();
            #4 rstn = 1'b1;
            for (int i = 0; i < 32; i++) begin
                step();
                pat_b[i] = bus.req_ready;
            end
            check("stall_repeat", pat_b, pat_a);
            check("stall_present", {31'b0, (pat_a != 32'hFFFFFFFF)}, 32'd1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
